// File: rtl/uart_defs.sv
// Shared definitions for the UART transmit sequencer.
package uart_defs;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned DIV_WIDTH_DEF  = 16;

  // Transmit sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Frame format, latched once per frame on accept.
  typedef struct packed {
    logic parity_en;
    logic parity_odd;
    logic stop2;
  } frame_cfg_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud-rate counter: counts 0..div and raises tick (registered) on the wrap count.
// div is the divisor in effect for the next cycle, so tick stays aligned
// with a divisor reloaded in the same cycle as clr.
module uart_baud_cnt
  import uart_defs::*;
#(
  parameter int unsigned DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick,
  output logic                 tick_nxt_c
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic                 tick_q;

  // Next count: restart on clr or on the wrap; tick_nxt_c is the tick of the next cycle.
  always_comb begin
    cnt_d = cnt_q + DIV_WIDTH'(1);
    if (clr || tick_q) begin
      cnt_d = '0;
    end
    tick_nxt_c = (cnt_d == div);
  end

  // Counter and tick registers; reset state is count 0 with divisor 0, i.e. on a wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_nxt_c;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts a byte over valid/ready and serializes
// start, data (LSB first), optional parity and 1/2 stop bits onto txd.
module uart_tx_ctrl
  import uart_defs::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DIV_WIDTH  = DIV_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  output logic                  txd,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int unsigned BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  frame_cfg_t            cfg_q, cfg_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ready_q, ready_d;

  logic                  accept_c;
  logic                  tick;
  logic                  tick_nxt_c;

  // Handshake and per-frame configuration capture.
  always_comb begin
    accept_c = valid_in & ready_q;
    div_d    = div_q;
    cfg_d    = cfg_q;
    if (accept_c) begin
      div_d = baud_div;
      cfg_d = '{parity_en: parity_en, parity_odd: parity_odd, stop2: stop2};
    end
  end

  uart_baud_cnt #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_cnt (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (accept_c),
    .div        (div_d),
    .tick       (tick),
    .tick_nxt_c (tick_nxt_c)
  );

  // Frame sequencer: next state, shift register, counters and txd.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    txd_d      = txd_q;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          txd_d     = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            if (cfg_q.parity_en) begin
              state_d = PARITY;
              txd_d   = (^data_q) ^ cfg_q.parity_odd;
            end else begin
              state_d    = STOP;
              stop_cnt_d = 1'b0;
              txd_d      = 1'b1;
            end
          end else begin
            shreg_d   = shreg_q >> 1;
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
            txd_d     = shreg_d[0];
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
          txd_d      = 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop_cnt_q == cfg_q.stop2) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // Accept is only possible in IDLE or the last stop clock; either way a new frame starts.
    if (accept_c) begin
      state_d   = START;
      data_d    = data_i;
      shreg_d   = data_i;
      bit_cnt_d = '0;
      txd_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // ready for the next cycle: idle, or the final clock of the final stop bit.
  always_comb begin
    ready_d = (state_d == IDLE) ||
              ((state_d == STOP) && (stop_cnt_d == cfg_d.stop2) && tick_nxt_c);
  end

  // State and output registers; a reset drops any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      data_q     <= '0;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      cfg_q      <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      cfg_q      <= cfg_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign ready_in   = ready_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl.
module tb_uart_tx_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  data_i;
  logic        valid_in;
  logic        ready_in;
  logic [15:0] baud_div;
  logic        parity_en;
  logic        parity_odd;
  logic        stop2;
  logic        txd;
  logic        busy;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(
    .DATA_WIDTH (8),
    .DIV_WIDTH  (16)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_i     (data_i),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .baud_div   (baud_div),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .stop2      (stop2),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  task automatic test_reset();
    rstn = 1'b0; valid_in = 1'b0; data_i = 8'h00; baud_div = 16'd0;
    parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0 || ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: txd=%b busy=%b done=%b rdy=%b, expected 1 0 0 0",
               txd, busy, frame_done, ready_in);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ready_in !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b txd=%b, expected 1 0 1", ready_in, busy, txd);
    end
  endtask

  // 0xA5, 4 clk/bit, no parity, one stop bit.
  task automatic test_basic();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    data_i = 8'hA5; baud_div = 16'd3; parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (txd !== exp_bits[c/4] || busy !== 1'b1 || frame_done !== 1'b0 || ready_in !== (c == 39)) begin
        errors++;
        $display("FAIL basic_frame c=%0d: txd=%b busy=%b done=%b rdy=%b, expected txd=%b busy=1 done=0 rdy=%b",
                 c, txd, busy, frame_done, ready_in, exp_bits[c/4], (c == 39));
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1 || ready_in !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: done=%b busy=%b txd=%b rdy=%b, expected 1 0 1 1",
               frame_done, busy, txd, ready_in);
    end
    @(negedge clk);
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse: done=%b, expected 0", frame_done);
    end
  endtask

  // 0x07 with even then odd parity, 2 clk/bit, 11-bit frames.
  task automatic test_parity();
    logic [10:0] exp_bits;
    for (int p = 0; p < 2; p++) begin
      exp_bits = (p == 0) ? 11'b11000001110 : 11'b10000001110;
      data_i = 8'h07; baud_div = 16'd1; parity_en = 1'b1; parity_odd = (p == 1); stop2 = 1'b0;
      valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      for (int c = 0; c < 22; c++) begin
        checks++;
        if (txd !== exp_bits[c/2] || busy !== 1'b1 || frame_done !== 1'b0) begin
          errors++;
          $display("FAIL parity_frame odd=%0d c=%0d: txd=%b busy=%b done=%b, expected txd=%b busy=1 done=0",
                   p, c, txd, busy, frame_done, exp_bits[c/2]);
        end
        @(negedge clk);
      end
      checks++;
      if (frame_done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL parity_done odd=%0d: done=%b busy=%b, expected 1 0", p, frame_done, busy);
      end
      @(negedge clk);
    end
    parity_en = 1'b0; parity_odd = 1'b0;
  endtask

  // Two stop bits at 1 clk/bit, second byte back-to-back with valid held.
  task automatic test_back_to_back();
    logic [10:0] exp_bits;
    data_i = 8'h3C; baud_div = 16'd0; stop2 = 1'b1; valid_in = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 2; f++) begin
      exp_bits = (f == 0) ? 11'b11001111000 : 11'b11110000110;
      for (int c = 0; c < 11; c++) begin
        checks++;
        if (txd !== exp_bits[c] || busy !== 1'b1 || frame_done !== (f == 1 && c == 0) ||
            ready_in !== (c == 10)) begin
          errors++;
          $display("FAIL b2b_frame f=%0d c=%0d: txd=%b busy=%b done=%b rdy=%b, expected txd=%b busy=1 done=%b rdy=%b",
                   f, c, txd, busy, frame_done, ready_in, exp_bits[c], (f == 1 && c == 0), (c == 10));
        end
        if (f == 0 && c == 0) data_i = 8'hC3;
        if (f == 1 && c == 0) valid_in = 1'b0;
        @(negedge clk);
      end
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b busy=%b txd=%b, expected 1 0 1", frame_done, busy, txd);
    end
    @(negedge clk);
    stop2 = 1'b0;
  endtask

  // baud_div changes 3->9 mid-frame; the next frame picks up the new rate.
  task automatic test_div_change();
    logic [9:0] exp_bits;
    exp_bits = 10'b1010110100;
    data_i = 8'h5A; baud_div = 16'd3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (txd !== exp_bits[c/4] || busy !== 1'b1) begin
        errors++;
        $display("FAIL divchg_frame1 c=%0d: txd=%b busy=%b, expected txd=%b busy=1",
                 c, txd, busy, exp_bits[c/4]);
      end
      if (c == 5) baud_div = 16'd9;
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divchg_done1: done=%b busy=%b, expected 1 0", frame_done, busy);
    end
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 100; c++) begin
      checks++;
      if (txd !== exp_bits[c/10] || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL divchg_frame2 c=%0d: txd=%b busy=%b done=%b, expected txd=%b busy=1 done=0",
                 c, txd, busy, frame_done, exp_bits[c/10]);
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL divchg_done2: done=%b busy=%b, expected 1 0", frame_done, busy);
    end
    @(negedge clk);
  endtask

  // Reset during data bit 3, then a complete frame afterwards.
  task automatic test_mid_frame_reset();
    logic [9:0] exp_bits;
    exp_bits = 10'b1101001010;
    data_i = 8'hA5; baud_div = 16'd3; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 17; c++) @(negedge clk);
    checks++;
    if (txd !== exp_bits[4] || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: txd=%b busy=%b, expected txd=%b busy=1", txd, busy, exp_bits[4]);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || ready_in !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: txd=%b busy=%b rdy=%b done=%b, expected 1 0 0 0",
               txd, busy, ready_in, frame_done);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (ready_in !== 1'b1 || busy !== 1'b0 || txd !== 1'b1) begin
      errors++;
      $display("FAIL rst_idle: rdy=%b busy=%b txd=%b, expected 1 0 1", ready_in, busy, txd);
    end
    exp_bits = 10'b1100101100;
    data_i = 8'h96; baud_div = 16'd1; valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (txd !== exp_bits[c/2] || busy !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL rst_next_frame c=%0d: txd=%b busy=%b done=%b, expected txd=%b busy=1 done=0",
                 c, txd, busy, frame_done, exp_bits[c/2]);
      end
      @(negedge clk);
    end
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_done: done=%b busy=%b, expected 1 0", frame_done, busy);
    end
    @(negedge clk);
  endtask

  // No valid for 20 clocks: line stays idle.
  task automatic test_idle();
    valid_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      checks++;
      if (txd !== 1'b1 || busy !== 1'b0 || ready_in !== 1'b1 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL idle c=%0d: txd=%b busy=%b rdy=%b done=%b, expected 1 0 1 0",
                 c, txd, busy, ready_in, frame_done);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_div_change();
    test_mid_frame_reset();
    test_idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
